treasure_report_ctrl: RTL and testbench
=======================================

Name: treasure_report_ctrl

Overview:
- Frame-level controller that sits between IMAGE_PROCESSOR and the Arduino parallel link.
- On an Arduino scan request it aligns to VGA frame boundaries and samples the processor's per-frame {RESULT, SHAPE} verdict.
- It votes across consecutive frames until the verdict is stable, then presents a 4-bit code over a level req/ack handshake with timeout.
- It debounces single-frame colour/shape glitches so the robot never acts on one noisy frame.

Parameters:
- STABLE_FRAMES, 3: consecutive identical frame verdicts required to report (range 1..15).
- MAX_FRAMES, 12: frames allowed in voting before reporting inconclusive (must be >= STABLE_FRAMES, <= 255).
- ACK_TIMEOUT, 50000: CLK cycles to wait for ARD_ACK before abandoning the report (<= 2^16-1).

Ports:
- CLK  in  1  system clock, same domain as IMAGE_PROCESSOR.
- RESET_N  in  1  synchronous active-low reset.
- VGA_VSYNC_NEG  in  1  frame sync, same signal fed to IMAGE_PROCESSOR.
- RESULT  in  2  processor colour verdict: 00 none, 01 red, 10 blue.
- SHAPE  in  2  processor shape verdict: 00 none, 01 diamond, 10 square, 11 triangle.
- ARD_REQ_SCAN  in  1  Arduino scan request, asynchronous level.
- ARD_ACK  in  1  Arduino data acknowledge, asynchronous level.
- DATA_OUT  out  4  reported code {colour[1:0], shape[1:0]}.
- DATA_VALID  out  1  DATA_OUT valid for the Arduino.
- BUSY  out  1  high in any state other than IDLE.
- TIMEOUT_ERR  out  1  sticky flag: last report was not acknowledged.

Behaviour:
- Clock is CLK. Reset is synchronous, active-low on RESET_N; one clock, no other reset.
- Reset values:
  - DATA_OUT=0000, DATA_VALID=0, BUSY=0, TIMEOUT_ERR=0, state=IDLE.
  - Vote and frame counters = 0; vsync history register = 1, which prevents a false edge out of reset.
- ARD_REQ_SCAN and ARD_ACK pass through 2-FF synchronizers, adding 2 cycles of latency. All rules below refer to the synchronized versions.
- Frame tick: asserted in the cycle where the registered previous VGA_VSYNC_NEG is 1 and the current value is 0.
- The processor updates RESULT/SHAPE in that same cycle, so the controller samples {RESULT, SHAPE} one cycle after the tick (sample strobe).
- Code formation: code = {RESULT, SHAPE}. If RESULT==00 or RESULT==11, code = 0000.
- IDLE:
  - If req=1, clear TIMEOUT_ERR and go to ARM.
  - If req=0, stay. Ticks are ignored.
- ARM: wait for the first sample strobe, discard that sample (the frame may be partial), clear counters, go to VOTE.
- VOTE, on each sample strobe:
  - frames+1.
  - If code==candidate and count>0, count+1; otherwise load candidate=code and set count=1.
  - If count reaches STABLE_FRAMES: latch DATA_OUT=candidate and go to REPORT. This takes priority over the frame limit in the same strobe.
  - Else if frames==MAX_FRAMES: latch DATA_OUT=1111 (inconclusive) and go to REPORT.
- If req drops in ARM or VOTE: return to IDLE; DATA_VALID stays 0.
- REPORT:
  - DATA_VALID=1 and DATA_OUT held constant.
  - The timeout counter increments every cycle.
  - On ack=1, go to RELEASE.
  - If the counter reaches ACK_TIMEOUT with no ack: set TIMEOUT_ERR, clear DATA_VALID, go to IDLE. If ack arrives in that same cycle, the ack wins.
- RELEASE: DATA_VALID=0 and DATA_OUT held. When ack=0 and req=0, go to IDLE.
- DATA_VALID rises only on entry to REPORT and never while ack=1.
- Counter widths:
  - count: 4 bits, saturating.
  - frames: 8 bits.
  - timeout: 16 bits.
- Reset asserted mid-operation returns everything to reset values on the next edge. DATA_VALID drops even mid-handshake.

Optional Feature:
- Macro: TREASURE_SHAPE_MASK_EN.
- Defined: the vote compares only RESULT, and the SHAPE field of DATA_OUT is forced to 00 (for colour-only runs when shape detection is unreliable). The inconclusive code stays 1111.
- Undefined: the full 4-bit code is voted and reported.

Decomposition:
- Shared package treasure_pkg contains:
  - State encoding: IDLE, ARM, VOTE, REPORT, RELEASE.
  - Colour constants: COL_NONE=00, COL_RED=01, COL_BLUE=10.
  - Shape constants: SHP_NONE=00, SHP_DIAMOND=01, SHP_SQUARE=10, SHP_TRIANGLE=11.
  - Codes: CODE_NONE=0000, CODE_INCONCLUSIVE=1111.
- One sub-module, sync_2ff (1-bit, reset to 0), instantiated twice for the Arduino inputs.

Test Plan:
- Stable red triangle: req=1, frames give code 0111 every frame. After the discarded frame plus 3 frames, DATA_OUT=0111 and DATA_VALID=1. Ack=1 clears DATA_VALID; dropping req and ack returns to IDLE with BUSY=0.
- Glitch rejection: frame codes 1010, 1010, 0110, 1010, 1010, 1010 -> report 1010 after the 6th voted frame.
- Inconclusive: codes alternate 0101/1001 for 12 frames -> DATA_OUT=1111, DATA_VALID=1.
- Ack timeout: ACK_TIMEOUT=100, stable code 0000, ack never asserted -> DATA_VALID drops 100 cycles after rising and TIMEOUT_ERR=1. Next req clears TIMEOUT_ERR.
- Invalid colour: RESULT=11, SHAPE=10 for 3 frames -> report 0000.
- Abort and reset: drop req in VOTE -> IDLE and no DATA_VALID. Separately, assert RESET_N=0 during REPORT -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/treasure_pkg.sv
// Shared state encoding, verdict constants and code formation for treasure_report_ctrl.
package treasure_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StVote,
        StReport,
        StRelease
    } state_e;

    localparam logic [1:0] COL_NONE     = 2'b00;
    localparam logic [1:0] COL_RED      = 2'b01;
    localparam logic [1:0] COL_BLUE     = 2'b10;

    localparam logic [1:0] SHP_NONE     = 2'b00;
    localparam logic [1:0] SHP_DIAMOND  = 2'b01;
    localparam logic [1:0] SHP_SQUARE   = 2'b10;
    localparam logic [1:0] SHP_TRIANGLE = 2'b11;

    localparam logic [3:0] CODE_NONE         = 4'b0000;
    localparam logic [3:0] CODE_INCONCLUSIVE = 4'b1111;

    // No colour (or the unused 11 encoding) means no treasure, regardless of shape.
    function automatic logic [3:0] form_code(input logic [1:0] result, input logic [1:0] shape);
        if (result == COL_RED || result == COL_BLUE) begin
            return {result, shape};
        end
        return CODE_NONE;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, synchronous reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/treasure_report_ctrl.sv
// Frame-voting treasure verdict reporter with req/ack handshake to the Arduino.
// Define TREASURE_SHAPE_MASK_EN to vote and report colour only (shape field forced to 00).
module treasure_report_ctrl
    import treasure_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 3,
    parameter int unsigned MAX_FRAMES    = 12,
    parameter int unsigned ACK_TIMEOUT   = 50000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       VGA_VSYNC_NEG,
    input  logic [1:0] RESULT,
    input  logic [1:0] SHAPE,
    input  logic       ARD_REQ_SCAN,
    input  logic       ARD_ACK,
    output logic [3:0] DATA_OUT,
    output logic       DATA_VALID,
    output logic       BUSY,
    output logic       TIMEOUT_ERR
);

    logic        req_s;
    logic        ack_s;

    state_e      state_q, state_d;
    logic        vsync_q;
    logic        strobe_q;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  count_q, count_d;
    logic [7:0]  frames_q, frames_d;
    logic [15:0] tmo_q, tmo_d;
    logic [3:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic        tick;
    logic [3:0]  raw_code;
    logic [3:0]  code;
    logic        match;
    logic [3:0]  vote_count;
    logic [7:0]  frames_inc;
    logic [15:0] tmo_inc;

    sync_2ff u_sync_req (
        .clk_i  (CLK),
        .rst_ni (RESET_N),
        .d_i    (ARD_REQ_SCAN),
        .q_o    (req_s)
    );

    sync_2ff u_sync_ack (
        .clk_i  (CLK),
        .rst_ni (RESET_N),
        .d_i    (ARD_ACK),
        .q_o    (ack_s)
    );

    assign tick     = vsync_q & ~VGA_VSYNC_NEG;
    assign raw_code = form_code(RESULT, SHAPE);

`ifdef TREASURE_SHAPE_MASK_EN
    assign code = {raw_code[3:2], SHP_NONE};
`else
    assign code = raw_code;
`endif

    assign match      = (code == cand_q) && (count_q != 4'd0);
    assign vote_count = !match ? 4'd1 : (count_q == 4'hf) ? count_q : count_q + 4'd1;
    assign frames_inc = frames_q + 8'd1;
    assign tmo_inc    = tmo_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        count_d  = count_q;
        frames_d = frames_q;
        tmo_d    = tmo_q;
        data_d   = data_q;
        valid_d  = valid_q;
        err_d    = err_q;

        case (state_q)
            StIdle: begin
                if (req_s) begin
                    err_d   = 1'b0;
                    state_d = StArm;
                end
            end
            StArm: begin
                if (!req_s) begin
                    state_d = StIdle;
                end else if (strobe_q) begin
                    // First frame after arming may be partial, so it is dropped.
                    cand_d   = CODE_NONE;
                    count_d  = 4'd0;
                    frames_d = 8'd0;
                    state_d  = StVote;
                end
            end
            StVote: begin
                if (!req_s) begin
                    state_d = StIdle;
                end else if (strobe_q) begin
                    frames_d = frames_inc;
                    count_d  = vote_count;
                    cand_d   = code;
                    if (vote_count == 4'(STABLE_FRAMES)) begin
                        data_d  = code;
                        valid_d = 1'b1;
                        tmo_d   = 16'd0;
                        state_d = StReport;
                    end else if (frames_inc == 8'(MAX_FRAMES)) begin
                        data_d  = CODE_INCONCLUSIVE;
                        valid_d = 1'b1;
                        tmo_d   = 16'd0;
                        state_d = StReport;
                    end
                end
            end
            StReport: begin
                tmo_d = tmo_inc;
                if (ack_s) begin
                    valid_d = 1'b0;
                    state_d = StRelease;
                end else if (tmo_inc == 16'(ACK_TIMEOUT)) begin
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StRelease: begin
                if (!ack_s && !req_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= StIdle;
            vsync_q  <= 1'b1;
            strobe_q <= 1'b0;
            cand_q   <= CODE_NONE;
            count_q  <= 4'd0;
            frames_q <= 8'd0;
            tmo_q    <= 16'd0;
            data_q   <= CODE_NONE;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            vsync_q  <= VGA_VSYNC_NEG;
            strobe_q <= tick;
            cand_q   <= cand_d;
            count_q  <= count_d;
            frames_q <= frames_d;
            tmo_q    <= tmo_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign DATA_OUT    = data_q;
    assign DATA_VALID  = valid_q;
    assign BUSY        = (state_q != StIdle);
    assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_treasure_report_ctrl.sv
// Directed bench for treasure_report_ctrl: voting, glitch rejection, timeout, abort and reset.
module tb_treasure_report_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b1;
    logic [1:0] result = 2'b00;
    logic [1:0] shape = 2'b00;
    logic       req = 1'b0;
    logic       ack = 1'b0;
    logic [3:0] data_out;
    logic       valid;
    logic       busy;
    logic       terr;

    int errors = 0;
    int checks = 0;
    int n;
    int w;

    treasure_report_ctrl #(
        .STABLE_FRAMES (3),
        .MAX_FRAMES    (12),
        .ACK_TIMEOUT   (100)
    ) dut (
        .CLK           (clk),
        .RESET_N       (rst_n),
        .VGA_VSYNC_NEG (vsync),
        .RESULT        (result),
        .SHAPE         (shape),
        .ARD_REQ_SCAN  (req),
        .ARD_ACK       (ack),
        .DATA_OUT      (data_out),
        .DATA_VALID    (valid),
        .BUSY          (busy),
        .TIMEOUT_ERR   (terr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One VGA frame: vsync low with the new verdict, then high again.
    task automatic frame(input logic [3:0] c);
        vsync  = 1'b0;
        result = c[3:2];
        shape  = c[1:0];
        repeat (4) @(negedge clk);
        vsync = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic start_scan(input string tag);
        req = 1'b1;
        repeat (4) @(negedge clk);
        check({tag, "_armed_busy"}, 16'(busy), 16'd1);
    endtask

    task automatic handshake(input string tag, input logic [3:0] held);
        ack = 1'b1;
        repeat (4) @(negedge clk);
        check({tag, "_rel_valid"}, 16'(valid), 16'd0);
        check({tag, "_rel_busy"}, 16'(busy), 16'd1);
        check({tag, "_rel_data"}, 16'(data_out), 16'(held));
        req = 1'b0;
        ack = 1'b0;
        repeat (4) @(negedge clk);
        check({tag, "_idle_busy"}, 16'(busy), 16'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", 16'(data_out), 16'h0);
        check("rst_valid", 16'(valid), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_terr", 16'(terr), 16'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Stable red triangle
        start_scan("t1");
        frame(4'b0111);
        frame(4'b0111);
        frame(4'b0111);
        check("t1_early_valid", 16'(valid), 16'd0);
        frame(4'b0111);
        check("t1_data", 16'(data_out), 16'h7);
        check("t1_valid", 16'(valid), 16'd1);
        handshake("t1", 4'b0111);

        // Single-frame glitch rejected
        start_scan("t2");
        frame(4'b0000);
        frame(4'b1010);
        frame(4'b1010);
        frame(4'b0110);
        frame(4'b1010);
        frame(4'b1010);
        check("t2_early_valid", 16'(valid), 16'd0);
        frame(4'b1010);
        check("t2_data", 16'(data_out), 16'ha);
        check("t2_valid", 16'(valid), 16'd1);
        handshake("t2", 4'b1010);

        // Alternating verdicts hit the frame limit
        start_scan("t3");
        frame(4'b0101);
        for (int i = 0; i < 11; i++) begin
            frame((i % 2 == 0) ? 4'b0101 : 4'b1001);
        end
        check("t3_early_valid", 16'(valid), 16'd0);
        frame(4'b1001);
        check("t3_data", 16'(data_out), 16'hf);
        check("t3_valid", 16'(valid), 16'd1);
        handshake("t3", 4'b1111);

        // Invalid colour encoding reports no treasure
        start_scan("t4");
        repeat (4) frame(4'b1110);
        check("t4_data", 16'(data_out), 16'h0);
        check("t4_valid", 16'(valid), 16'd1);
        handshake("t4", 4'b0000);

        // Abort during voting
        start_scan("t5");
        frame(4'b0110);
        frame(4'b0110);
        req = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_busy", 16'(busy), 16'd0);
        check("t5_valid", 16'(valid), 16'd0);
        repeat (3) frame(4'b0110);
        check("t5_no_report", 16'(valid), 16'd0);
        check("t5_data", 16'(data_out), 16'h0);

        // Ack never arrives
        start_scan("t6");
        frame(4'b0000);
        frame(4'b0000);
        frame(4'b0000);
        vsync  = 1'b0;
        result = 2'b00;
        shape  = 2'b00;
        w = 0;
        while (!valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        vsync = 1'b1;
        check("t6_rise", 16'(valid), 16'd1);
        check("t6_data", 16'(data_out), 16'h0);
        n = 0;
        while (valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("t6_len", 16'(n), 16'd100);
        check("t6_terr", 16'(terr), 16'd1);
        check("t6_busy", 16'(busy), 16'd0);
        @(negedge clk);
        check("t6_terr_clr", 16'(terr), 16'd0);
        check("t6_rearm", 16'(busy), 16'd1);
        req = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_idle", 16'(busy), 16'd0);

        // Reset while reporting
        start_scan("t7");
        repeat (4) frame(4'b1001);
        check("t7_data", 16'(data_out), 16'h9);
        check("t7_valid", 16'(valid), 16'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t7_rst_data", 16'(data_out), 16'h0);
        check("t7_rst_valid", 16'(valid), 16'd0);
        check("t7_rst_busy", 16'(busy), 16'd0);
        check("t7_rst_terr", 16'(terr), 16'd0);
        rst_n = 1'b1;
        req = 1'b0;
        repeat (4) @(negedge clk);
        check("t7_after_busy", 16'(busy), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
